// File: rtl/d_ff_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with per-stage valids, bubble collapsing,
// synchronous flush and a registered occupancy count.
module d_ff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             D,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [WIDTH-1:0]             Q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_nxt;

  // A stage may load when it is empty or its successor is loading this edge,
  // so a bubble anywhere downstream lets the whole chain behind it advance.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !vld[i] || rdy[i+1];
    end
  end

  assign in_ready  = rdy[0] && !flush && reset_n;
  assign push      = in_valid && in_ready;
  assign out_valid = vld[DEPTH-1];
  assign Q         = dat[DEPTH-1];
  assign pop       = out_valid && out_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Control: stage valids and occupancy; flush wins over push and advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld   <= '0;
      count <= '0;
    end else if (flush) begin
      vld   <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (rdy[0]) vld[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) vld[i] <= vld[i-1];
      end
    end
  end

  // Data: loads only when a valid word moves in, otherwise holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) dat[i] <= RESET_VAL;
    end else if (!flush) begin
      if (push) dat[0] <= D;
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i] && vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

endmodule

// File: tb/tb_d_ff_pipe.sv
// Directed bench for d_ff_pipe: a DEPTH=4 instance for the main scenarios and a
// DEPTH=1 instance for the single-register case.
module tb_d_ff_pipe;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;

  logic [7:0] d_a = '0;
  logic       iv_a = 1'b0, ir_a, fl_a = 1'b0, ov_a, or_a = 1'b0;
  logic [7:0] q_a;
  logic [2:0] cnt_a;

  logic [7:0] d_b = '0;
  logic       iv_b = 1'b0, ir_b, fl_b = 1'b0, ov_b, or_b = 1'b0;
  logic [7:0] q_b;
  logic [0:0] cnt_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut_a (
    .clock(clock), .reset_n(reset_n), .D(d_a), .in_valid(iv_a), .in_ready(ir_a),
    .flush(fl_a), .Q(q_a), .out_valid(ov_a), .out_ready(or_a), .count(cnt_a)
  );

  d_ff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut_b (
    .clock(clock), .reset_n(reset_n), .D(d_b), .in_valid(iv_b), .in_ready(ir_b),
    .flush(fl_b), .Q(q_b), .out_valid(ov_b), .out_ready(or_b), .count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic edge_step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    // Asynchronous reset between edges
    #3 reset_n = 1'b0;
    #1;
    chk("rst_q",     32'(q_a),   32'h00);
    chk("rst_ov",    32'(ov_a),  0);
    chk("rst_cnt",   32'(cnt_a), 0);
    chk("rst_ir",    32'(ir_a),  0);
    chk("rst_ov_b",  32'(ov_b),  0);
    chk("rst_ir_b",  32'(ir_b),  0);
    edge_step();
    edge_step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_ir", 32'(ir_a), 1);

    // Latency: one word through an empty pipe
    or_a = 1'b1; d_a = 8'hA5; iv_a = 1'b1;
    #1 chk("lat_ir", 32'(ir_a), 1);
    edge_step();
    iv_a = 1'b0;
    chk("lat_cnt_k", 32'(cnt_a), 1);
    chk("lat_ov_k",  32'(ov_a),  0);
    edge_step();
    edge_step();
    chk("lat_ov_k2", 32'(ov_a), 0);
    edge_step();
    chk("lat_ov_k3", 32'(ov_a), 1);
    chk("lat_q_k3",  32'(q_a),  32'hA5);
    chk("lat_cnt_k3", 32'(cnt_a), 1);
    edge_step();
    chk("lat_ov_pop",  32'(ov_a),  0);
    chk("lat_cnt_pop", 32'(cnt_a), 0);

    // Backpressure: fill to capacity, then drain
    or_a = 1'b0;
    for (int j = 0; j < 4; j++) begin
      d_a = 8'h11 * 8'(j + 1); iv_a = 1'b1;
      edge_step();
    end
    chk("bp_cnt_full", 32'(cnt_a), 4);
    chk("bp_q_head",   32'(q_a),   32'h11);
    d_a = 8'h55;
    #1 chk("bp_ir_full", 32'(ir_a), 0);
    edge_step();
    chk("bp_cnt_hold", 32'(cnt_a), 4);
    chk("bp_q_hold",   32'(q_a),   32'h11);
    or_a = 1'b1;
    #1 chk("bp_ir_popfull", 32'(ir_a), 1);
    edge_step();
    iv_a = 1'b0;
    chk("bp_q1", 32'(q_a), 32'h22);
    chk("bp_c1", 32'(cnt_a), 4);
    edge_step();
    chk("bp_q2", 32'(q_a), 32'h33);
    chk("bp_c2", 32'(cnt_a), 3);
    edge_step();
    chk("bp_q3", 32'(q_a), 32'h44);
    edge_step();
    chk("bp_q4", 32'(q_a), 32'h55);
    chk("bp_c4", 32'(cnt_a), 1);
    edge_step();
    chk("bp_ov_empty", 32'(ov_a), 0);
    chk("bp_c_empty",  32'(cnt_a), 0);
    chk("bp_q_holds",  32'(q_a), 32'h55);

    // Full pipe with simultaneous push and pop
    or_a = 1'b0;
    for (int j = 0; j < 4; j++) begin
      d_a = 8'h60 + 8'(j); iv_a = 1'b1;
      edge_step();
    end
    chk("fpp_cnt", 32'(cnt_a), 4);
    or_a = 1'b1;
    for (int j = 0; j < 10; j++) begin
      d_a = 8'h64 + 8'(j); iv_a = 1'b1;
      #1;
      chk("fpp_ir", 32'(ir_a), 1);
      chk("fpp_q",  32'(q_a),  32'h60 + 32'(j));
      edge_step();
      chk("fpp_cnt_hold", 32'(cnt_a), 4);
    end
    iv_a = 1'b0;
    chk("fpp_q_after", 32'(q_a), 32'h6A);
    for (int j = 0; j < 4; j++) edge_step();
    chk("fpp_drained", 32'(cnt_a), 0);

    // Flush with three words in flight
    or_a = 1'b0;
    for (int j = 0; j < 3; j++) begin
      d_a = 8'h71 + 8'(j); iv_a = 1'b1;
      edge_step();
    end
    chk("fl_cnt3", 32'(cnt_a), 3);
    fl_a = 1'b1; d_a = 8'h7F; iv_a = 1'b1;
    #1 chk("fl_ir", 32'(ir_a), 0);
    edge_step();
    fl_a = 1'b0; iv_a = 1'b0;
    chk("fl_cnt0", 32'(cnt_a), 0);
    chk("fl_ov0",  32'(ov_a),  0);
    edge_step();
    chk("fl_ignored", 32'(cnt_a), 0);
    d_a = 8'h80; iv_a = 1'b1;
    edge_step();
    iv_a = 1'b0; or_a = 1'b1;
    chk("fl_cnt1", 32'(cnt_a), 1);
    edge_step();
    edge_step();
    edge_step();
    chk("fl_ov_first", 32'(ov_a), 1);
    chk("fl_q_first",  32'(q_a),  32'h80);
    edge_step();
    chk("fl_cnt_end", 32'(cnt_a), 0);

    // Mid-stream asynchronous reset
    or_a = 1'b0;
    d_a = 8'h91; iv_a = 1'b1; edge_step();
    d_a = 8'h92; edge_step();
    iv_a = 1'b0;
    chk("mrst_cnt2", 32'(cnt_a), 2);
    #3 reset_n = 1'b0;
    #1;
    chk("mrst_cnt", 32'(cnt_a), 0);
    chk("mrst_ov",  32'(ov_a),  0);
    chk("mrst_q",   32'(q_a),   32'h00);
    chk("mrst_ir",  32'(ir_a),  0);
    edge_step();
    reset_n = 1'b1;
    edge_step();
    chk("mrst_stay", 32'(cnt_a), 0);

    // DEPTH=1 streaming and stall
    or_b = 1'b1;
    for (int j = 0; j < 6; j++) begin
      d_b = 8'hC0 + 8'(j); iv_b = 1'b1;
      #1 chk("d1_ir", 32'(ir_b), 1);
      edge_step();
      chk("d1_ov",  32'(ov_b),  1);
      chk("d1_q",   32'(q_b),   32'hC0 + 32'(j));
      chk("d1_cnt", 32'(cnt_b), 1);
    end
    iv_b = 1'b0;
    edge_step();
    chk("d1_ov_end",  32'(ov_b),  0);
    chk("d1_cnt_end", 32'(cnt_b), 0);
    or_b = 1'b0; d_b = 8'hD1; iv_b = 1'b1;
    edge_step();
    d_b = 8'hD2;
    #1 chk("d1_ir_full", 32'(ir_b), 0);
    edge_step();
    chk("d1_q_hold", 32'(q_b), 32'hD1);
    or_b = 1'b1;
    #1 chk("d1_ir_pop", 32'(ir_b), 1);
    edge_step();
    iv_b = 1'b0;
    chk("d1_q_next", 32'(q_b), 32'hD2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
